// File: rtl/ram_burst_ctrl_d0.sv
// rtl/ram_burst_ctrl_d0.sv - burst sequencer for the d0 data RAM
// Streams write beats into the RAM, or reads it into a 2-entry buffer drained over valid/ready.
module ram_burst_ctrl_d0 #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic [AWIDTH-1:0] remaining_q, remaining_d;
  logic [AWIDTH-1:0] len_q, len_d;
  logic [AWIDTH:0]   issued_q, issued_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [DWIDTH-1:0] buf_q [2];
  logic [DWIDTH-1:0] buf_d [2];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        count_q, count_d;

  logic              wr_hs;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    issued_d    = issued_q;
    done_d      = 1'b0;
    buf_d[0]    = buf_q[0];
    buf_d[1]    = buf_q[1];
    head_d      = head_q;
    tail_d      = tail_q;

    wr_hs = (state_q == ST_WRITE) && wr_valid;
    pop   = (state_q == ST_READ) && (count_q != 2'd0) && rd_ready;
    // Projected buffer fill once the in-flight word lands; issue only if a slot stays free.
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == ST_READ) && (issued_q <= {1'b0, len_q}) && (occupancy < 3'd2);
    inflight_d = issue;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ptr_d       = cmd_addr;
          remaining_d = cmd_len;
          len_d       = cmd_len;
          issued_d    = '0;
          state_d     = cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_valid) begin
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          ptr_d    = ptr_q + 1'b1;
          issued_d = issued_q + 1'b1;
        end
        // In READ, remaining counts beats still to be popped.
        if (pop) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (inflight_q) begin
      buf_d[tail_q] = ram_dout;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign wr_ready  = (state_q == ST_WRITE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ram_addr  = ptr_q;
  assign ram_din   = wr_data;
  assign ram_we    = wr_hs;
  assign rd_valid  = (count_q != 2'd0);
  assign rd_data   = buf_q[head_q];

endmodule

// File: tb/tb_ram_burst_ctrl_d0.sv
// tb/tb_ram_burst_ctrl_d0.sv - scoreboard bench for ram_burst_ctrl_d0
module tb_ram_burst_ctrl_d0;

  logic        clock;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr, cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done;
  logic [2:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_we;

  int tests = 0;
  int errors = 0;
  int pops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem [8];
  logic [31:0] mem [8];
  int          wcount [8];
  logic [2:0]  raddr_q;

  ram_burst_ctrl_d0 #(.AWIDTH(3), .DWIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous-read RAM: address registered on the edge, data read combinationally from it.
  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i] = 32'h0;
      exp_mem[i] = 32'h0;
      wcount[i] = 0;
    end
  end

  always @(posedge clock) begin
    if (ram_we) begin
      mem[ram_addr]    <= ram_din;
      wcount[ram_addr] <= wcount[ram_addr] + 1;
    end
    raddr_q <= ram_addr;
  end
  assign ram_dout = mem[raddr_q];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && rd_valid && rd_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {32'h0, rd_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("rd_beat", {32'h0, rd_data}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_write(input int addr, input int len, input logic [31:0] base);
    for (int i = 0; i < 8; i++) wcount[i] = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 3'(addr); cmd_len = 3'(len);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    check("wr_busy", {63'h0, busy}, 64'h1);
    check("wr_ready", {63'h0, wr_ready}, 64'h1);
    for (int i = 0; i <= len; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      exp_mem[(addr + i) % 8] = base + 32'(i);
      @(negedge clock);
      check("wr_we", {63'h0, ram_we}, 64'h1);
      check("wr_addr", {61'h0, ram_addr}, 64'((addr + i) % 8));
      @(posedge clock); #1;
    end
    wr_valid = 1'b0;
    check("wr_done", {63'h0, done}, 64'h1);
    check("wr_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    check("wr_we_off", {63'h0, ram_we}, 64'h0);
    @(posedge clock); #1;
    check("wr_done_pulse", {63'h0, done}, 64'h0);
    for (int i = 0; i <= len; i++) begin
      check("wr_mem", {32'h0, mem[(addr + i) % 8]}, {32'h0, base + 32'(i)});
      check("wr_once", 64'(wcount[(addr + i) % 8]), 64'h1);
    end
  endtask

  task automatic do_read(input int addr, input int len, input bit toggle);
    int first;
    int done_cyc;
    int pops0;
    pops0 = pops;
    first = -1;
    done_cyc = -1;
    for (int i = 0; i <= len; i++) exp_q.push_back(exp_mem[(addr + i) % 8]);
    cmd_valid = 1'b1; cmd_write = 1'b0;
    cmd_addr = 3'(addr); cmd_len = 3'(len);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    check("rd_busy", {63'h0, busy}, 64'h1);
    for (int k = 1; k <= 80; k++) begin
      rd_ready = toggle ? (k % 3 == 1) : 1'b1;
      wr_valid = toggle;
      @(posedge clock); #1;
      if (rd_valid && first < 0) first = k;
      if (toggle) check("rd_no_we", {63'h0, ram_we}, 64'h0);
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    check("rd_timeout", {63'h0, done_cyc >= 0}, 64'h1);
    if (!toggle) begin
      check("rd_latency", 64'(first), 64'h2);
      check("rd_done_cycle", 64'(done_cyc), 64'(len + 3));
    end
    check("rd_beat_count", 64'(pops - pops0), 64'(len + 1));
    check("rd_queue_empty", 64'(exp_q.size()), 64'h0);
    check("rd_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    @(posedge clock); #1;
    check("rd_done_pulse", {63'h0, done}, 64'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_len = 3'd0;
    wr_valid = 1'b0; wr_data = 32'h0; rd_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    check("rst_wr_ready", {63'h0, wr_ready}, 64'h0);
    check("rst_rd_valid", {63'h0, rd_valid}, 64'h0);
    check("rst_rd_data", {32'h0, rd_data}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_ram_addr", {61'h0, ram_addr}, 64'h0);
    check("rst_ram_we", {63'h0, ram_we}, 64'h0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    do_write(2, 3, 32'hA0);
    do_read(2, 3, 1'b0);
    do_write(0, 7, 32'h10);
    do_read(6, 3, 1'b0);
    do_read(0, 7, 1'b1);
    do_write(5, 7, 32'h50);

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_len = 3'd7;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    check("pre_rst_rd_valid", {63'h0, rd_valid}, 64'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rd_valid", {63'h0, rd_valid}, 64'h0);
    check("mid_rst_busy", {63'h0, busy}, 64'h0);
    check("mid_rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    check("mid_rst_ram_we", {63'h0, ram_we}, 64'h0);
    check("mid_rst_rd_data", {32'h0, rd_data}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    do_read(5, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
